cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Main-FSM controller for the 4-way set-associative L1 cache. It sequences tag compare, dirty-victim writeback and line allocate between the CPU-side request port and the physical-memory port. It drives the datapath's per-way load strobes and the PLRU update strobe, and consumes the PLRU victim way together with the hit/dirty status from the datapath.

## Interface
- NUM_WAYS, 4, ways per set; the only supported value, so way indices are 2 bits.
- CNT_W, 32, width of each performance counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  CPU read request; held high until mem_resp.
- mem_write  in  1  CPU write request; held high until mem_resp.
- mem_resp  out  1  one-cycle completion strobe to the CPU.
- hit  in  1  datapath: a valid tag match exists in the addressed set.
- hit_way  in  2  datapath: index of the matching way.
- victim_way  in  2  PLRU: replacement way (empty way first, otherwise pseudo-LRU).
- victim_dirty  in  1  datapath: dirty bit of way victim_way.
- pmem_read  out  1  memory read request, level.
- pmem_write  out  1  memory write request, level.
- pmem_resp  in  1  memory completion strobe.
- way_sel  out  2  way driven onto the datapath data/tag muxes.
- addr_sel  out  1  0 = CPU address to pmem; 1 = {victim tag, index} to pmem (writeback).
- write_hit  out  1  write CPU data into way way_sel and set its dirty bit.
- load_line  out  1  write pmem line into way way_sel; tag loaded, valid=1, dirty=0.
- load_plru  out  1  update PLRU for the way touched this cycle.
- hit_count, miss_count, wb_count  out  CNT_W each  performance counters.

## Operation
- States: S_IDLE (compare), S_WB, S_ALLOC.
- req = mem_read | mem_write. When both are high, the request is treated as a write.
- S_IDLE with req & hit:
  - mem_resp=1, load_plru=1, way_sel=hit_way, write_hit=mem_write.
  - Stay in S_IDLE.
- S_IDLE with req & ~hit:
  - Register victim_q <= victim_way.
  - Next state is S_WB if victim_dirty, else S_ALLOC.
  - No mem_resp.
- S_IDLE with ~req: all strobes 0; pmem_resp is ignored.
- S_WB:
  - pmem_write=1, addr_sel=1, way_sel=victim_q.
  - On pmem_resp, go to S_ALLOC.
- S_ALLOC:
  - pmem_read=1, addr_sel=0, way_sel=victim_q.
  - On pmem_resp: load_line=1, load_plru=1, go to S_IDLE.
- After the refill, S_IDLE re-compares. The request now hits and completes through the hit path.
- victim_q is frozen from miss detect until return to S_IDLE, so PLRU updates cannot redirect an in-flight fill.
- A request dropped during S_WB or S_ALLOC does not abort the miss. The line is still allocated and no mem_resp is issued.
- Counters (when compiled in):
  - hit_count increments on each S_IDLE hit response.
  - miss_count increments on each S_IDLE→S_WB/S_ALLOC transition.
  - wb_count increments on each S_WB exit.
  - All counters saturate at all-ones and never wrap.

## Timing
- Reset: state=S_IDLE, victim_q=0, counters=0.
- Outputs during reset: mem_resp, pmem_read, pmem_write, write_hit, load_line, load_plru, addr_sel and way_sel are all 0.
- Outputs take their reset values immediately on rst assertion, asynchronously.
- Reset mid-miss abandons the pmem transaction; pmem_read/pmem_write drop in the same cycle.
- In S_IDLE all outputs are Moore on state plus combinational on req/hit/hit_way. In S_WB and S_ALLOC, way_sel and addr_sel come from state and victim_q only.
- Hit latency: mem_resp in the same cycle the request is presented (0 wait cycles).
- Clean miss latency: 1 cycle S_IDLE + N_read cycles S_ALLOC + 1 cycle re-compare.
- Dirty miss latency: adds N_write cycles in S_WB.
- pmem_read/pmem_write stay high until the cycle in which pmem_resp is sampled. They drop on the following edge. At most one of the two is high at any time.
- A pmem_resp arriving in the same cycle as the state entry edge counts for the new state.

## Configuration
- CACHE_CTRL_PERF_CNT_EN defined: hit/miss/writeback counters are instantiated and behave as described.
- Not defined: no counter flops; hit_count, miss_count and wb_count are tied to 0. The port list is unchanged.

## Structure
- Shared package cache_types_pkg holds:
  - typedef way_t (logic [1:0]);
  - enum cache_ctrl_state_t {S_IDLE, S_WB, S_ALLOC};
  - localparam NUM_WAYS = 4.
- Sub-module cache_perf_cnt holds the three saturating counters. It is instantiated only under CACHE_CTRL_PERF_CNT_EN.

## Test plan
- Read, hit=1, hit_way=2 → mem_resp same cycle, way_sel=2, load_plru=1, write_hit=0; hit_count 0→1.
- Write, hit=1, hit_way=1 → mem_resp, write_hit=1, way_sel=1; state remains S_IDLE.
- Read miss, victim_way=3, victim_dirty=0, pmem_resp after 5 cycles → S_ALLOC for 5 cycles, load_line=1 with way_sel=3, next cycle hit → mem_resp. miss_count=1, wb_count=0.
- Read miss, victim_way=0, dirty=1 → pmem_write with addr_sel=1 until pmem_resp, then pmem_read with addr_sel=0. victim_way changed to 2 during S_WB → way_sel stays 0. wb_count=1.
- rst asserted mid-S_ALLOC → pmem_read=0 immediately, state S_IDLE, counters 0.
- hit_count preloaded near all-ones (CNT_W=4, 15 hits, then 2 more) → hit_count holds 15.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Shared types for the L1 cache controller: way index, main FSM states, way count.
package cache_types_pkg;

  localparam int NUM_WAYS = 4;

  typedef logic [$clog2(NUM_WAYS)-1:0] way_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WB    = 2'd1,
    S_ALLOC = 2'd2
  } cache_ctrl_state_t;

endpackage

// File: rtl/cache_perf_cnt.sv
// Saturating hit/miss/writeback event counters for the cache controller.
module cache_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit_inc,
  input  logic             miss_inc,
  input  logic             wb_inc,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [CNT_W-1:0] wb_q, wb_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    wb_d   = wb_q;
    if (hit_inc && (hit_q != '1)) hit_d = hit_q + 1'b1;
    if (miss_inc && (miss_q != '1)) miss_d = miss_q + 1'b1;
    if (wb_inc && (wb_q != '1)) wb_d = wb_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
      wb_q   <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
      wb_q   <= wb_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign wb_count   = wb_q;

endmodule

// File: rtl/cache_ctrl.sv
// Main FSM of the 4-way L1 cache: tag compare, dirty-victim writeback, line allocate.
// Performance counters are built only when CACHE_CTRL_PERF_CNT_EN is defined.
//
// state   | meaning
// S_IDLE  | compare; hits respond in the same cycle, misses latch the victim
// S_WB    | write the dirty victim line back to pmem
// S_ALLOC | read the missing line from pmem into the victim way
module cache_ctrl
  import cache_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             hit,
  input  logic [1:0]       hit_way,
  input  logic [1:0]       victim_way,
  input  logic             victim_dirty,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic [1:0]       way_sel,
  output logic             addr_sel,
  output logic             write_hit,
  output logic             load_line,
  output logic             load_plru,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  cache_ctrl_state_t state_q, state_d;
  way_t              victim_q, victim_d;
  logic              req;

  assign req = mem_read | mem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    way_sel    = '0;
    addr_sel   = 1'b0;
    write_hit  = 1'b0;
    load_line  = 1'b0;
    load_plru  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && hit) begin
          mem_resp  = 1'b1;
          load_plru = 1'b1;
          way_sel   = hit_way;
          write_hit = mem_write;
        end else if (req) begin
          victim_d = victim_way;
          state_d  = victim_dirty ? S_WB : S_ALLOC;
        end
      end
      S_WB: begin
        pmem_write = 1'b1;
        addr_sel   = 1'b1;
        way_sel    = victim_q;
        if (pmem_resp) state_d = S_ALLOC;
      end
      S_ALLOC: begin
        pmem_read = 1'b1;
        way_sel   = victim_q;
        if (pmem_resp) begin
          load_line = 1'b1;
          load_plru = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Idle outputs follow req/hit combinationally, so reset must mask them directly.
    if (rst) begin
      mem_resp   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      way_sel    = '0;
      addr_sel   = 1'b0;
      write_hit  = 1'b0;
      load_line  = 1'b0;
      load_plru  = 1'b0;
    end
  end

`ifdef CACHE_CTRL_PERF_CNT_EN
  logic hit_ev, miss_ev, wb_ev;

  assign hit_ev  = mem_resp;
  assign miss_ev = (state_q == S_IDLE) && (state_d != S_IDLE);
  assign wb_ev   = (state_q == S_WB) && (state_d != S_WB);

  cache_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .clk        (clk),
    .rst        (rst),
    .hit_inc    (hit_ev),
    .miss_inc   (miss_ev),
    .wb_inc     (wb_ev),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
  );
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized scoreboard bench for cache_ctrl against a one-set tag/valid/dirty model.
module tb_cache_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic mem_read, mem_write, mem_resp, hit, victim_dirty;
  logic [1:0] hit_way, victim_way, way_sel;
  logic pmem_read, pmem_write, pmem_resp, addr_sel, write_hit, load_line, load_plru;
  logic [CNT_W-1:0] hit_count, miss_count, wb_count;

  cache_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit(hit), .hit_way(hit_way), .victim_way(victim_way), .victim_dirty(victim_dirty),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .way_sel(way_sel), .addr_sel(addr_sel), .write_hit(write_hit), .load_line(load_line),
    .load_plru(load_plru), .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed { logic [1:0] way; logic wr; } resp_t;
  resp_t      resp_q[$];
  logic [1:0] fill_q[$];
  logic [1:0] wb_q[$];

  bit v_valid[4];
  bit v_dirty[4];
  int v_tag[4];
  int n_hit, n_miss, n_wb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cexp(input int n);
`ifdef CACHE_CTRL_PERF_CNT_EN
    int mx;
    mx = (1 << CNT_W) - 1;
    return (n > mx) ? mx : n;
`else
    return (n < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  function automatic int lookup(input int t);
    for (int i = 0; i < 4; i++) if (v_valid[i] && v_tag[i] == t) return i;
    return -1;
  endfunction

  function automatic int pick_victim();
    for (int i = 0; i < 4; i++) if (!v_valid[i]) return i;
    return $urandom_range(0, 3);
  endfunction

  // Monitor: pops expected events whenever the DUT presents a strobe.
  always @(negedge clk) begin : mon
    resp_t      r;
    logic [1:0] w;
    if (!rst) begin
      chk("pmem_exclusive", pmem_read & pmem_write, 0);
      if (mem_resp) begin
        if (resp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL resp_unexpected: actual mem_resp=1 required 0 (t=%0t)", $time);
        end else begin
          r = resp_q.pop_front();
          chk("resp_way_sel", way_sel, r.way);
          chk("resp_write_hit", write_hit, r.wr);
          chk("resp_load_plru", load_plru, 1);
        end
      end
      if (load_line) begin
        if (fill_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL fill_unexpected: actual load_line=1 required 0 (t=%0t)", $time);
        end else begin
          w = fill_q.pop_front();
          chk("fill_way_sel", way_sel, w);
          chk("fill_load_plru", load_plru, 1);
          chk("fill_addr_sel", addr_sel, 0);
        end
      end
      if (pmem_write && pmem_resp) begin
        if (wb_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL wb_unexpected: actual pmem_write=1 required 0 (t=%0t)", $time);
        end else begin
          w = wb_q.pop_front();
          chk("wb_way_sel", way_sel, w);
          chk("wb_addr_sel", addr_sel, 1);
        end
      end
    end
  end

  task automatic phase(input bit is_wb, input int v, input int lat, input bit drop);
    for (int i = 0; i < lat; i++) begin
      @(posedge clk); #1;
      pmem_resp    = (i == lat - 1);
      victim_way   = 2'(v + 1 + $urandom_range(0, 2));
      victim_dirty = 1'($urandom);
      hit          = 1'($urandom);
      hit_way      = 2'($urandom);
      if (drop && i == 0) begin mem_read = 0; mem_write = 0; end
      @(negedge clk);
      chk(is_wb ? "wb_pmem_write" : "alloc_pmem_read", is_wb ? pmem_write : pmem_read, 1);
      chk(is_wb ? "wb_no_read" : "alloc_no_write", is_wb ? pmem_read : pmem_write, 0);
      chk("miss_addr_sel", addr_sel, is_wb);
      chk("miss_way_frozen", way_sel, v);
      chk("miss_no_resp", mem_resp, 0);
      chk("miss_load_line", load_line, !is_wb && (i == lat - 1));
    end
  endtask

  task automatic do_req(input bit wr, input bit both, input int t, input int vforce,
                        input int nw, input int nr, input bit drop);
    int w, v;
    bit d;
    w = lookup(t);
    @(posedge clk); #1;
    mem_read  = !wr || both;
    mem_write = wr;
    pmem_resp = 1'($urandom);
    if (w >= 0) begin
      hit = 1; hit_way = 2'(w);
      victim_way = 2'($urandom); victim_dirty = 1'($urandom);
      resp_q.push_back('{way: 2'(w), wr: wr});
      n_hit++;
      if (wr) v_dirty[w] = 1;
      @(negedge clk);
      chk("hit_latency", mem_resp, 1);
      chk("hit_no_pmem", pmem_read | pmem_write, 0);
    end else begin
      v = (vforce >= 0) ? vforce : pick_victim();
      d = v_valid[v] && v_dirty[v];
      hit = 0; hit_way = 2'($urandom);
      victim_way = 2'(v); victim_dirty = d;
      n_miss++;
      @(negedge clk);
      chk("miss_detect_no_resp", mem_resp | pmem_read | pmem_write, 0);
      if (d) begin
        wb_q.push_back(2'(v));
        n_wb++;
        phase(1, v, nw, drop);
      end
      fill_q.push_back(2'(v));
      phase(0, v, nr, drop);
      v_valid[v] = 1; v_tag[v] = t; v_dirty[v] = 0;
      @(posedge clk); #1;
      pmem_resp = 0;
      hit = 1; hit_way = 2'(v);
      if (!drop) begin
        resp_q.push_back('{way: 2'(v), wr: wr});
        n_hit++;
        if (wr) v_dirty[v] = 1;
      end
      @(negedge clk);
      chk("recompare_resp", mem_resp, !drop);
      chk("recompare_no_pmem", pmem_read | pmem_write, 0);
    end
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0; hit = 0; pmem_resp = 0;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mem_read = 0; mem_write = 0;
      hit = 1'($urandom); hit_way = 2'($urandom); pmem_resp = 1'($urandom);
      @(negedge clk);
      chk("idle_no_strobes",
          {mem_resp, load_plru, load_line, write_hit, pmem_read, pmem_write}, 0);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_hit_count"}, hit_count, cexp(n_hit));
    chk({tag, "_miss_count"}, miss_count, cexp(n_miss));
    chk({tag, "_wb_count"}, wb_count, cexp(n_wb));
  endtask

  initial begin : drv
    int t;
    bit wr, both, drop;
    rst = 1; mem_read = 1; mem_write = 0; hit = 1; hit_way = 2'd3;
    victim_way = 0; victim_dirty = 0; pmem_resp = 0;
    for (int i = 0; i < 4; i++) begin v_valid[i] = 1; v_dirty[i] = 0; v_tag[i] = 10 + i; end
    n_hit = 0; n_miss = 0; n_wb = 0;
    #12;
    chk("reset_outputs", {mem_resp, pmem_read, pmem_write, write_hit, load_line,
                          load_plru, addr_sel, way_sel}, 0);
    chk_cnt("reset");
    @(negedge clk); #2;
    rst = 0; mem_read = 0; hit = 0;

    do_req(0, 0, 12, -1, 1, 1, 0);      // read hit way 2
    chk_cnt("read_hit");
    do_req(1, 0, 11, -1, 1, 1, 0);      // write hit way 1
    do_req(0, 0, 20, 3, 1, 5, 0);       // clean miss into way 3, 5-cycle read
    chk_cnt("clean_miss");
    do_req(1, 1, 10, -1, 1, 1, 0);      // dirty way 0 via write hit
    do_req(0, 0, 21, 0, 4, 3, 0);       // dirty miss: writeback then fill way 0
    chk_cnt("dirty_miss");
    idle_gap(3);

    // Reset in the middle of a refill.
    @(posedge clk); #1;
    mem_read = 1; mem_write = 0; hit = 0; victim_way = 2'd1; victim_dirty = 0; pmem_resp = 0;
    @(negedge clk);
    @(posedge clk); #1;
    hit = 1; hit_way = 2'd1;
    @(negedge clk);
    chk("alloc_before_rst", pmem_read, 1);
    #2; rst = 1; #1;
    chk("rst_drops_pmem_read", pmem_read, 0);
    chk("rst_outputs", {mem_resp, pmem_write, write_hit, load_line, load_plru,
                        addr_sel, way_sel}, 0);
    n_hit = 0; n_miss = 0; n_wb = 0;
    chk_cnt("mid_alloc_rst");
    @(negedge clk); #2;
    rst = 0; mem_read = 0; hit = 0;

    for (int k = 0; k < 80; k++) begin
      t    = $urandom_range(10, 17);
      wr   = 1'($urandom);
      both = wr && ($urandom_range(0, 7) == 0);
      drop = ($urandom_range(0, 9) == 0);
      do_req(wr, both, t, -1, $urandom_range(1, 6), $urandom_range(1, 6), drop);
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
    end
    chk_cnt("random");

    for (int k = 0; k < 20; k++) do_req(0, 0, v_tag[k % 4], -1, 1, 1, 0);
    chk_cnt("saturate");
    idle_gap(2);

    chk("resp_q_drained", resp_q.size(), 0);
    chk("fill_q_drained", fill_q.size(), 0);
    chk("wb_q_drained", wb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
